// File: rtl/tt_um_mult_seq_ctrl.sv
// Sequential 4x4 shift-add multiplier with start-edge detect and busy/done/overflow flags.
// Define MULT_ACC_EN to accumulate products into uo_out with a sticky overflow flag.
module tt_um_mult_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] res_q, res_d;
  logic [1:0] step_q, step_d;
  logic       start_q, start_d;
  logic       armed_q, armed_d;
  logic       ovf_q, ovf_d;

  logic       start_evt;
  logic [7:0] addend;
  logic [7:0] sum_next;
`ifdef MULT_ACC_EN
  logic [8:0] acc_sum;
`endif
  logic       unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:1]};

  // armed_q blocks a start level that was already high when reset released.
  assign start_evt = uio_in[0] & ~start_q & armed_q;
  assign addend    = b_q[step_q] ? ({4'b0000, a_q} << step_q) : 8'd0;
  assign sum_next  = sum_q + addend;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    res_d   = res_q;
    step_d  = step_q;
    start_d = start_q;
    armed_d = armed_q;
    ovf_d   = ovf_q;
`ifdef MULT_ACC_EN
    acc_sum = {1'b0, res_q} + {1'b0, sum_next};
`endif
    if (ena) begin
      start_d = uio_in[0];
      armed_d = armed_q | ~uio_in[0];
      unique case (state_q)
        StIdle: begin
`ifdef MULT_ACC_EN
          if (uio_in[1]) begin
            res_d = 8'd0;
            ovf_d = 1'b0;
          end
`endif
          if (start_evt) begin
            a_d     = ui_in[3:0];
            b_d     = ui_in[7:4];
            sum_d   = 8'd0;
            step_d  = 2'd0;
            state_d = StRun;
          end
        end
        StRun: begin
          sum_d  = sum_next;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = StDone;
`ifdef MULT_ACC_EN
            res_d = acc_sum[7:0];
            ovf_d = ovf_q | acc_sum[8];
`else
            res_d = sum_next;
`endif
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      sum_q   <= 8'd0;
      res_q   <= 8'd0;
      step_q  <= 2'd0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      step_q  <= step_d;
      start_q <= start_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {1'b0, ovf_q, (state_q == StDone), (state_q == StRun), 4'b0000};
  assign uio_oe  = 8'b0111_0000;

endmodule

// File: tb/tb_tt_um_mult_seq_ctrl.sv
// Scoreboard bench for tt_um_mult_seq_ctrl: stimulus pushes expected results, a monitor
// pops and checks on each done pulse. Define MULT_ACC_EN to exercise accumulate mode.
`timescale 1ns/1ps
module tb_tt_um_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         busy;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_uo  = 8'd0;
  logic       model_ovf = 1'b0;
  logic [7:0] prev_uo;

  tt_um_mult_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after edge T0.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p,
                       input int bexp, input bit clr, input bit push);
`ifdef MULT_ACC_EN
    logic [8:0] sum9;
`endif
    if (push) begin
`ifdef MULT_ACC_EN
      if (clr) begin
        model_uo  = 8'd0;
        model_ovf = 1'b0;
      end
      sum9      = {1'b0, model_uo} + {1'b0, p};
      model_uo  = sum9[7:0];
      model_ovf = model_ovf | sum9[8];
`else
      model_uo = p;
`endif
      exp_q.push_back('{model_uo, model_ovf, bexp});
    end
    ui_in  = {b, a};
    uio_in = {6'b0, clr, 1'b1};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the scoreboard.
  int   bcnt      = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt      = 0;
      done_prev = 1'b0;
    end else begin
      if (uio_out[4]) bcnt++;
      if (uio_out[5] && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with result %0d, expected no operation", uo_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", uo_out, e.res);
          check("overflow", uio_out[6], e.ovf);
          check("busy_cycles", bcnt, e.busy);
        end
        bcnt = 0;
      end
      done_prev = uio_out[5];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h01;
    idle(2);
    check("rst_uo_out", uo_out, 8'd0);
    check("rst_uio_out", uio_out, 8'd0);
    check("uio_oe", uio_oe, 8'h70);

    // Start already high at reset release must not launch an operation.
    rst_n = 1'b1;
    idle(4);
    check("held_start_after_reset", uio_out, 8'd0);
    uio_in = 8'h00;
    idle(1);

    issue(4'd15, 4'd15, 8'd225, 4, 1'b0, 1'b1);
    idle(8);
    issue(4'd0, 4'd7, 8'd0, 4, 1'b0, 1'b1);
    idle(8);
    issue(4'd9, 4'd0, 8'd0, 4, 1'b0, 1'b1);
    idle(8);
    issue(4'd3, 4'd5, 8'd15, 4, 1'b0, 1'b1);
    idle(8);

    // Start held high for 20 cycles: exactly one operation.
    model_uo = model_uo + 8'd6;
`ifndef MULT_ACC_EN
    model_uo = 8'd6;
`endif
    exp_q.push_back('{model_uo, model_ovf, 4});
    ui_in  = 8'h32;
    uio_in = 8'h01;
    idle(20);
    uio_in = 8'h00;
    idle(2);
    check("hold_after_long_start", uo_out, model_uo);

    // Second start pulse and operand change mid-run are ignored.
    issue(4'd4, 4'd4, 8'd16, 4, 1'b0, 1'b1);
    idle(1);
    ui_in  = 8'h11;
    uio_in = 8'h01;
    idle(1);
    uio_in = 8'h00;
    idle(8);
    check("no_queued_start", uo_out, model_uo);

    // Reset asserted just after T2 of 15x15.
    issue(4'd15, 4'd15, 8'd225, 4, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #2;
    check("midrun_rst_uo_out", uo_out, 8'd0);
    check("midrun_rst_uio_out", uio_out, 8'd0);
    model_uo  = 8'd0;
    model_ovf = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    issue(4'd7, 4'd6, 8'd42, 4, 1'b0, 1'b1);
    idle(8);

    // ena low for 3 cycles mid-run stretches busy by 3.
    prev_uo = model_uo;
    issue(4'd13, 4'd11, 8'd143, 7, 1'b0, 1'b1);
    idle(1);
    ena = 1'b0;
    @(negedge clk);
    check("stall_busy", uio_out[4], 1'b1);
    check("stall_uo_hold", uo_out, prev_uo);
    idle(3);
    ena = 1'b1;
    idle(10);

`ifdef MULT_ACC_EN
    uio_in = 8'h02;
    idle(1);
    uio_in = 8'h00;
    model_uo  = 8'd0;
    model_ovf = 1'b0;
    check("clear_uo", uo_out, 8'd0);
    check("clear_ovf", uio_out[6], 1'b0);
    issue(4'd3, 4'd5, 8'd15, 4, 1'b0, 1'b1);
    idle(8);
    check("acc_15", uo_out, 8'd15);
    issue(4'd15, 4'd15, 8'd225, 4, 1'b0, 1'b1);
    idle(8);
    check("acc_240", uo_out, 8'd240);
    issue(4'd2, 4'd8, 8'd16, 4, 1'b0, 1'b1);
    idle(8);
    check("acc_wrap", uo_out, 8'd0);
    check("acc_ovf", uio_out[6], 1'b1);
    uio_in = 8'h02;
    idle(1);
    uio_in = 8'h00;
    model_uo  = 8'd0;
    model_ovf = 1'b0;
    check("clear2_uo", uo_out, 8'd0);
    check("clear2_ovf", uio_out[6], 1'b0);
    issue(4'd5, 4'd5, 8'd25, 4, 1'b0, 1'b1);
    idle(8);
    issue(4'd1, 4'd1, 8'd1, 4, 1'b1, 1'b1);
    idle(8);
    check("clear_with_start", uo_out, 8'd1);
`else
    prev_uo = uo_out;
    uio_in = 8'h02;
    idle(1);
    uio_in = 8'h00;
    check("clear_ignored", uo_out, 8'd143);
    check("ovf_zero", uio_out[6], 1'b0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
